alu_pipe: RTL and testbench

Parametrised two-stage pipelined ALU with valid/ready handshakes on input and output, an 8-operation opcode set and a saturating overflow-event counter. It generalises the fixed 8-bit combinational opcode ALU into a width-configurable, back-pressure-aware datapath element. It sits between an operand-issue stage and a result-consuming stage.

---
 rtl/alu_pipe.sv | 175 +++++++++++++++++
 tb/tb_alu_pipe.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes on both sides
// and a saturating count of delivered overflow beats.
module alu_pipe #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       opcode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic             ovf,
   output logic [CNT_W-1:0] ovf_count
);

   localparam int unsigned OP_W = 3;

   localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
   localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
   localparam logic [OP_W-1:0] OP_PSA  = 3'b010;
   localparam logic [OP_W-1:0] OP_PSB  = 3'b011;
   localparam logic [OP_W-1:0] OP_AND  = 3'b100;
   localparam logic [OP_W-1:0] OP_OR   = 3'b101;
   localparam logic [OP_W-1:0] OP_XOR  = 3'b110;
   localparam logic [OP_W-1:0] OP_SADD = 3'b111;

   // stage 1: captured operands
   logic             s1_valid_q, s1_valid_d;
   logic [OP_W-1:0]  s1_op_q,    s1_op_d;
   logic [WIDTH-1:0] s1_a_q,     s1_a_d;
   logic [WIDTH-1:0] s1_b_q,     s1_b_d;

   // stage 2: registered results
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] s2_res_q,   s2_res_d;
   logic             s2_carry_q, s2_carry_d;
   logic             s2_zero_q,  s2_zero_d;
   logic             s2_ovf_q,   s2_ovf_d;

   logic [CNT_W-1:0] cnt_q,      cnt_d;

   // combinational ALU results from stage 1
   logic [WIDTH:0]   sum_w;
   logic [WIDTH:0]   diff_w;
   logic [WIDTH-1:0] alu_res;
   logic             alu_carry;
   logic             alu_ovf;
   logic             a_msb;
   logic             b_msb;

   logic             accept;
   logic             out_hs;
   logic             s2_load;

   // Ready when a slot frees this cycle; held high in reset, low during flush.
   assign in_ready = !reset || (!clear && (!s1_valid_q || !s2_valid_q || out_ready));

   assign accept  = in_valid && in_ready;
   assign out_hs  = s2_valid_q && out_ready;
   assign s2_load = s1_valid_q && (!s2_valid_q || out_ready);

   assign out_valid = s2_valid_q;
   assign result    = s2_res_q;
   assign carry     = s2_carry_q;
   assign zero      = s2_zero_q;
   assign ovf       = s2_ovf_q;
   assign ovf_count = cnt_q;

   // Opcode datapath evaluated on the stage-1 operands at WIDTH+1 bits.
   always_comb begin
      a_msb     = s1_a_q[WIDTH-1];
      b_msb     = s1_b_q[WIDTH-1];
      sum_w     = {1'b0, s1_a_q} + {1'b0, s1_b_q};
      diff_w    = {1'b0, s1_a_q} - {1'b0, s1_b_q};
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_ovf   = 1'b0;
      case (s1_op_q)
         OP_ADD: begin
            alu_res   = sum_w[WIDTH-1:0];
            alu_carry = sum_w[WIDTH];
            alu_ovf   = (a_msb == b_msb) && (sum_w[WIDTH-1] != a_msb);
         end
         OP_SUB: begin
            alu_res   = diff_w[WIDTH-1:0];
            alu_carry = diff_w[WIDTH];
            alu_ovf   = (a_msb != b_msb) && (diff_w[WIDTH-1] != a_msb);
         end
         OP_PSA: alu_res = s1_a_q;
         OP_PSB: alu_res = s1_b_q;
         OP_AND: alu_res = s1_a_q & s1_b_q;
         OP_OR:  alu_res = s1_a_q | s1_b_q;
         OP_XOR: alu_res = s1_a_q ^ s1_b_q;
         OP_SADD: begin
            alu_res   = sum_w[WIDTH] ? {WIDTH{1'b1}} : sum_w[WIDTH-1:0];
            alu_carry = sum_w[WIDTH];
            alu_ovf   = sum_w[WIDTH];
         end
         default: alu_res = '0;
      endcase
   end

   // Next-state: reset beats flush, flush beats normal pipeline advance.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_op_d    = s1_op_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s2_valid_d = s2_valid_q;
      s2_res_d   = s2_res_q;
      s2_carry_d = s2_carry_q;
      s2_zero_d  = s2_zero_q;
      s2_ovf_d   = s2_ovf_q;
      cnt_d      = cnt_q;
      if (!reset) begin
         s1_valid_d = 1'b0;
         s1_op_d    = '0;
         s1_a_d     = '0;
         s1_b_d     = '0;
         s2_valid_d = 1'b0;
         s2_res_d   = '0;
         s2_carry_d = 1'b0;
         s2_zero_d  = 1'b0;
         s2_ovf_d   = 1'b0;
         cnt_d      = '0;
      end else if (clear) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end else begin
         if (out_hs && s2_ovf_q && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         if (s2_load) begin
            s2_valid_d = 1'b1;
            s2_res_d   = alu_res;
            s2_carry_d = alu_carry;
            s2_zero_d  = (alu_res == WIDTH'(0));
            s2_ovf_d   = alu_ovf;
         end else if (out_hs) begin
            s2_valid_d = 1'b0;
         end
         if (accept) begin
            s1_valid_d = 1'b1;
            s1_op_d    = opcode;
            s1_a_d     = a;
            s1_b_d     = b;
         end else if (s2_load) begin
            s1_valid_d = 1'b0;
         end
      end
   end

   // State registers; reset is applied synchronously through the _d logic.
   always_ff @(posedge clock) begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_carry_q <= s2_carry_d;
      s2_zero_q  <= s2_zero_d;
      s2_ovf_q   <= s2_ovf_d;
      cnt_q      <= cnt_d;
   end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and random stimulus against a queue-based reference
// model of the ALU pipeline (WIDTH=8, CNT_W=2).
module tb_alu_pipe;

   localparam int unsigned W   = 8;
   localparam int unsigned CW  = 2;
   localparam int          CNT_MAX = 3;

   logic          clock = 1'b0;
   logic          reset, clear, in_valid, in_ready, out_valid, out_ready;
   logic [2:0]    opcode;
   logic [W-1:0]  a, b, result;
   logic          carry, zero, ovf;
   logic [CW-1:0] ovf_count;

   typedef struct {
      logic [7:0] res;
      logic       c;
      logic       z;
      logic       o;
      int         stamp;
   } exp_t;

   exp_t q[$];
   int   cnt      = 0;
   int   edge_cnt = 0;
   bit   known    = 0;
   int   n_assert = 0;
   int   n_fail   = 0;

   alu_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
      .clock(clock), .reset(reset), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .carry(carry), .zero(zero), .ovf(ovf),
      .ovf_count(ovf_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference ALU written from plain integer arithmetic.
   function automatic exp_t model(input logic [2:0] op, input logic [7:0] av, input logic [7:0] bv);
      exp_t e;
      int ua = int'(av);
      int ub = int'(bv);
      int sa = (ua >= 128) ? ua - 256 : ua;
      int sb = (ub >= 128) ? ub - 256 : ub;
      int s;
      e.c = 1'b0;
      e.o = 1'b0;
      e.stamp = 0;
      case (op)
         3'd0: begin
            s = ua + ub; e.res = 8'(s); e.c = (s > 255);
            e.o = ((sa + sb) > 127) || ((sa + sb) < -128);
         end
         3'd1: begin
            s = ua - ub; e.res = 8'(s); e.c = (ua < ub);
            e.o = ((sa - sb) > 127) || ((sa - sb) < -128);
         end
         3'd2: e.res = av;
         3'd3: e.res = bv;
         3'd4: e.res = av & bv;
         3'd5: e.res = av | bv;
         3'd6: e.res = av ^ bv;
         default: begin
            s = ua + ub; e.c = (s > 255);
            e.res = e.c ? 8'hFF : 8'(s); e.o = e.c;
         end
      endcase
      e.z = (e.res == 8'h00);
      return e;
   endfunction

   // One clock cycle: check outputs before the edge, then advance the model.
   task automatic step(output bit acc);
      bit   exp_ir, exp_ov, hs_out;
      exp_t h;
      #1;
      exp_ir = !reset ? 1'b1 : (clear ? 1'b0 : (q.size() < 2 || out_ready));
      chk("in_ready", 32'(in_ready), 32'(exp_ir));
      exp_ov = 1'b0;
      if (known) begin
         exp_ov = (q.size() > 0) && (q[0].stamp < edge_cnt);
         chk("out_valid", 32'(out_valid), 32'(exp_ov));
         chk("ovf_count", 32'(ovf_count), 32'(cnt));
         if (exp_ov) begin
            h = q[0];
            chk("result", 32'(result), 32'(h.res));
            chk("carry",  32'(carry),  32'(h.c));
            chk("zero",   32'(zero),   32'(h.z));
            chk("ovf",    32'(ovf),    32'(h.o));
         end
      end
      acc    = reset && !clear && in_valid && exp_ir;
      hs_out = exp_ov && out_ready;
      h      = model(opcode, a, b);
      @(posedge clock);
      edge_cnt++;
      if (!reset) begin
         q.delete();
         cnt   = 0;
         known = 1'b1;
      end else if (clear) begin
         q.delete();
      end else begin
         if (hs_out) begin
            if (q[0].o && cnt < CNT_MAX) cnt++;
            void'(q.pop_front());
         end
         if (acc) begin
            h.stamp = edge_cnt;
            q.push_back(h);
         end
      end
      @(negedge clock);
   endtask

   task automatic send(input logic [2:0] op, input logic [7:0] av, input logic [7:0] bv);
      bit acc = 1'b0;
      opcode   = op;
      a        = av;
      b        = bv;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(acc);
         if (acc) break;
      end
      in_valid = 1'b0;
      if (!acc) chk("accept_timeout", 32'(0), 32'(1));
   endtask

   task automatic idle(input int n);
      bit acc;
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) step(acc);
   endtask

   initial begin
      bit acc;
      // reset held two cycles with a beat offered
      reset = 1'b0; clear = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      opcode = 3'd0; a = 8'h11; b = 8'h22;
      step(acc);
      step(acc);
      chk("rst_result", 32'(result), 32'(0));
      chk("rst_carry",  32'(carry),  32'(0));
      chk("rst_zero",   32'(zero),   32'(0));
      chk("rst_ovf",    32'(ovf),    32'(0));
      reset = 1'b1;
      in_valid = 1'b0;

      // first beat after reset, then an opcode sweep
      send(3'd0, 8'h05, 8'h03);
      idle(3);
      send(3'd0, 8'h7F, 8'h01);
      send(3'd1, 8'h00, 8'h01);
      send(3'd7, 8'hF0, 8'h20);
      send(3'd6, 8'hAA, 8'hAA);
      send(3'd3, 8'h13, 8'h5C);
      send(3'd2, 8'hC3, 8'h00);
      send(3'd4, 8'hF0, 8'h3C);
      send(3'd5, 8'hF0, 8'h0F);
      send(3'd1, 8'h80, 8'h01);
      send(3'd7, 8'h10, 8'h20);
      idle(3);

      // back-pressure: two beats buffered, downstream stalls four cycles
      send(3'd0, 8'h01, 8'h02);
      send(3'd1, 8'h09, 8'h04);
      out_ready = 1'b0;
      opcode = 3'd6; a = 8'h0F; b = 8'hFF; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) step(acc);
      out_ready = 1'b1;
      send(3'd6, 8'h0F, 8'hFF);
      send(3'd4, 8'h33, 8'h0F);
      send(3'd0, 8'h80, 8'h80);
      send(3'd5, 8'h00, 8'h00);
      idle(4);

      // full throughput: 16 back-to-back beats
      for (int i = 0; i < 16; i++) send(3'(i), 8'(i * 17), 8'(255 - i * 13));
      idle(4);

      // flush with two beats in flight
      send(3'd0, 8'h7F, 8'h7F);
      send(3'd0, 8'h80, 8'hFF);
      clear = 1'b1;
      in_valid = 1'b1;
      step(acc);
      clear = 1'b0;
      in_valid = 1'b0;
      idle(3);
      send(3'd0, 8'h20, 8'h22);
      idle(3);

      // counter saturation from a fresh reset; first overflow beat stalls
      reset = 1'b0;
      step(acc);
      reset = 1'b1;
      out_ready = 1'b0;
      send(3'd0, 8'h7F, 8'h7F);
      idle(4);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send(3'd0, 8'h7F, 8'h7F);
         idle(2);
      end
      chk("ovf_count_sat", 32'(ovf_count), 32'(CNT_MAX));

      // random traffic with occasional flush and reset
      for (int i = 0; i < 500; i++) begin
         in_valid  = ($urandom % 4) != 0;
         out_ready = ($urandom % 4) != 0;
         opcode    = 3'($urandom);
         case ($urandom % 4)
            0:       a = 8'h7F;
            1:       a = 8'h80;
            default: a = 8'($urandom);
         endcase
         case ($urandom % 4)
            0:       b = 8'hFF;
            1:       b = 8'h01;
            default: b = 8'($urandom);
         endcase
         clear = ($urandom % 32) == 0;
         reset = ($urandom % 64) != 0;
         step(acc);
      end
      clear = 1'b0;
      reset = 1'b1;
      out_ready = 1'b1;
      idle(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
